// File: rtl/key_range_dispatcher.sv
// Key-range dispatcher: hands out fixed-size key chunks to a pool of search
// cores in round-robin order, tracks which cores hold an outstanding chunk,
// and reports either the first key found or exhaustion of the key space.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; req/found ignored
// DISPATCH  | granting chunks to requesting cores
// DRAIN     | whole space handed out; waiting for outstanding chunks
// FOUND     | a core reported a valid key; stop/done/success asserted
// EXHAUSTED | every chunk finished without a find; stop/done asserted
module key_range_dispatcher #(
    parameter int          NCORES     = 4,
    parameter int          CHUNK_LOG2 = 16,
    parameter logic [23:0] KEY_MAX    = 24'h3FFFFF
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    found,
    input  logic [24*NCORES-1:0] core_key,
    output logic [NCORES-1:0]    grant,
    output logic [23:0]          chunk_base,
    output logic [23:0]          chunk_last,
    output logic                 stop,
    output logic                 done,
    output logic                 success,
    output logic [23:0]          found_key
);

    localparam int          PTR_W       = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [24:0] CHUNK_SIZE  = 25'd1 << CHUNK_LOG2;
    localparam logic [24:0] KEY_MAX_EXT = {1'b0, KEY_MAX};

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        FOUND,
        EXHAUSTED
    } state_t;

    state_t state;
    state_t state_nxt;

    // next_key is one bit wider than a key so the final increment past
    // KEY_MAX cannot wrap back into the search space.
    logic [24:0]       next_key;
    logic [NCORES-1:0] active;
    logic [PTR_W-1:0]  rr_ptr;

    logic [NCORES-1:0] eligible;
    logic [NCORES-1:0] grant_nxt;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_hit;
    logic [24:0]       chunk_end;
    logic [23:0]       chunk_last_nxt;
    logic [23:0]       found_key_nxt;
    logic              any_found;
    logic              do_grant;
    logic              do_find;
    logic              do_restart;
    logic              track_active;

    // A core that is being granted this cycle is still showing its stale
    // request; masking it keeps grants to one core from going back-to-back.
    assign eligible  = req & ~grant;
    assign any_found = |found;

    assign chunk_end      = next_key + CHUNK_SIZE - 25'd1;
    assign chunk_last_nxt = (chunk_end > KEY_MAX_EXT) ? KEY_MAX : chunk_end[23:0];

    assign stop    = (state == FOUND) || (state == EXHAUSTED);
    assign done    = stop;
    assign success = (state == FOUND);

    // Round-robin pick: first eligible core at or after the pointer.
    always_comb begin
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(rr_ptr) + k) % NCORES;
            if (!grant_hit && eligible[idx]) begin
                grant_hit = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    // Lowest-index reporting core wins when several find in the same cycle.
    always_comb begin
        found_key_nxt = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (found[i]) begin
                found_key_nxt = core_key[24*i +: 24];
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = '0;
        do_grant     = 1'b0;
        do_find      = 1'b0;
        do_restart   = 1'b0;
        track_active = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    do_restart = 1'b1;
                    state_nxt  = DISPATCH;
                end
            end
            DISPATCH: begin
                track_active = 1'b1;
                if (any_found) begin
                    do_find   = 1'b1;
                    state_nxt = FOUND;
                end else if (grant_hit) begin
                    do_grant             = 1'b1;
                    grant_nxt[grant_idx] = 1'b1;
                    if (chunk_last_nxt == KEY_MAX) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                track_active = 1'b1;
                if (any_found) begin
                    do_find   = 1'b1;
                    state_nxt = FOUND;
                end else if (active == '0) begin
                    state_nxt = EXHAUSTED;
                end
            end
            FOUND, EXHAUSTED: begin
                if (start) begin
                    do_restart = 1'b1;
                    state_nxt  = DISPATCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: key cursor, chunk outputs, ownership tracking, winning key.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            next_key   <= '0;
            active     <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
            chunk_base <= '0;
            chunk_last <= '0;
            found_key  <= '0;
        end else begin
            grant <= grant_nxt;
            if (do_restart) begin
                next_key  <= '0;
                active    <= '0;
                rr_ptr    <= '0;
                found_key <= '0;
            end
            if (do_grant) begin
                chunk_base <= next_key[23:0];
                chunk_last <= chunk_last_nxt;
                next_key   <= next_key + CHUNK_SIZE;
                rr_ptr     <= (grant_idx == PTR_W'(NCORES - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            // A re-request retires the core's previous chunk; a new grant
            // in the same cycle re-claims it.
            if (track_active) begin
                active <= (active & ~req) | grant_nxt;
            end
            if (do_find) begin
                found_key <= found_key_nxt;
            end
        end
    end

endmodule
